stump_imm_encoder: RTL and testbench

- Inverse of the Stump sign-extension path: takes a 16-bit value plus the ext_op immediate format selector and produces the compact immediate field D[7:0] that sign-extends back to that value.
- ext_op=1 selects the 8-bit form and ext_op=0 the 5-bit form, matching the sign extender's convention.
- Reports whether the value is representable, buffers results in a 2-entry FIFO with valid/ready handshakes, and counts out-of-range requests.
- Used by the assembler/test-vector unit and the debug instruction injector.

---
 rtl/stump_imm_encoder.sv | 96 +++++++++
 tb/tb_stump_imm_encoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/stump_imm_encoder.sv
// Stump immediate encoder: 16-bit value + ext_op -> compact D[7:0] field, fit flag,
// 2-entry result FIFO and saturating out-of-range counter. Optional macro: STUMP_IMM_SATURATE_EN.
module stump_imm_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_value,
  input  logic             in_ext_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_D,
  output logic             out_ext_op,
  output logic             out_fits,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  typedef struct packed {
    logic [7:0] d;
    logic       ext_op;
    logic       fits;
  } entry_t;

  entry_t           r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_err_count;

  logic       w_fits8;
  logic       w_fits5;
  logic       w_fits;
  logic [7:0] w_d;
  logic       w_push;
  logic       w_pop;

  // A value fits when every bit above the immediate's sign bit copies that sign bit.
  assign w_fits8 = (&in_value[15:7]) | ~(|in_value[15:7]);
  assign w_fits5 = (&in_value[15:4]) | ~(|in_value[15:4]);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_fits = in_ext_op ? w_fits8 : w_fits5;
    w_d    = in_ext_op ? in_value[7:0] : {3'b000, in_value[4:0]};
`ifdef STUMP_IMM_SATURATE_EN
    if (!w_fits) begin
      if (in_ext_op) w_d = in_value[15] ? 8'h80 : 8'h7F;
      else           w_d = in_value[15] ? 8'h10 : 8'h0F;
    end
`endif
  end

  assign in_ready  = (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // The head entry drives the outputs directly; it is stale (not cleared) once the FIFO empties.
  assign out_D      = r_mem[r_rd_ptr].d;
  assign out_ext_op = r_mem[r_rd_ptr].ext_op;
  assign out_fits   = r_mem[r_rd_ptr].fits;
  assign err_count  = r_err_count;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two storage entries are reset because they drive out_* directly and must read 0 after reset.
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_err_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{d: w_d, ext_op: in_ext_op, fits: w_fits};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      if (err_clr)
        r_err_count <= '0;
      else if (w_push && !w_fits && !(&r_err_count))
        r_err_count <= r_err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stump_imm_encoder.sv
// Scoreboard bench for stump_imm_encoder: directed requests push expected entries,
// a negedge monitor pops and compares every entry the DUT hands over.
module tb_stump_imm_encoder;

  localparam int CNT_W = 2;

`ifdef STUMP_IMM_SATURATE_EN
  localparam logic [7:0] D_0080 = 8'h7F;
  localparam logic [7:0] D_1000 = 8'h0F;
`else
  localparam logic [7:0] D_0080 = 8'h80;
  localparam logic [7:0] D_1000 = 8'h00;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_value;
  logic             in_ext_op;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_D;
  logic             out_ext_op;
  logic             out_fits;
  logic             err_clr;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  // Expected entry: {D, ext_op, fits}
  logic [9:0] sb [$];

  stump_imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_ext_op(in_ext_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_D(out_D), .out_ext_op(out_ext_op),
    .out_fits(out_fits), .err_clr(err_clr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handed-over head must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        check("out_D",      {24'd0, out_D},      {24'd0, e[9:2]});
        check("out_ext_op", {31'd0, out_ext_op}, {31'd0, e[1]});
        check("out_fits",   {31'd0, out_fits},   {31'd0, e[0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until accepted (bounded); record the expected result at acceptance.
  task automatic issue(input logic [15:0] v, input logic ext,
                       input logic [7:0] d, input logic fits);
    bit done;
    done      = 1'b0;
    in_valid  = 1'b1;
    in_value  = v;
    in_ext_op = ext;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back({d, ext, fits});
        done = 1'b1;
      end
      tick();
    end
    if (!done) check("issue_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"},  {31'd0, out_valid},  32'd0);
    check({tag, "_in_ready"},   {31'd0, in_ready},   32'd1);
    check({tag, "_out_D"},      {24'd0, out_D},      32'd0);
    check({tag, "_out_ext_op"}, {31'd0, out_ext_op}, 32'd0);
    check({tag, "_out_fits"},   {31'd0, out_fits},   32'd0);
    check({tag, "_err_count"},  {30'd0, err_count},  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_value = '0; in_ext_op = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset_state("reset");

    // 5-bit form, negative value that fits
    out_ready = 1'b1;
    issue(16'hFFF3, 1'b0, 8'h13, 1'b1);
    idle();
    check("first_latency_valid", {31'd0, out_valid}, 32'd1);
    check("first_err_count", {30'd0, err_count}, 32'd0);
    tick();

    // 8-bit form boundary: 0x007F fits, 0x0080 does not
    issue(16'h007F, 1'b1, 8'h7F, 1'b1);
    issue(16'h0080, 1'b1, D_0080, 1'b0);
    idle();
    tick();
    check("err_after_0080", {30'd0, err_count}, 32'd1);

    // Fill with consumer stalled, third request must stall
    out_ready = 1'b0;
    issue(16'h0001, 1'b0, 8'h01, 1'b1);
    issue(16'hFFFF, 1'b0, 8'h1F, 1'b1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_value = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    idle();
    out_ready = 1'b1;
    tick(); tick();
    check("drained_in_ready", {31'd0, in_ready}, 32'd1);
    check("drained_out_valid", {31'd0, out_valid}, 32'd0);

    // count=1 with simultaneous push/pop for 10 cycles
    out_ready = 1'b0;
    issue(16'h0005, 1'b1, 8'h05, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] v;
      v = 16'hFFF0 + 16'(i);
      issue(v, 1'b0, {3'b000, v[4:0]}, 1'b1);
      check("stream_out_valid", {31'd0, out_valid}, 32'd1);
    end
    idle();
    tick();
    check("stream_drained", {31'd0, out_valid}, 32'd0);

    // Saturating error counter and err_clr priority
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_cleared", {30'd0, err_count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      issue(16'h1000, 1'b0, D_1000, 1'b0);
      idle();
      check("err_sat_step", {30'd0, err_count}, (i < 3) ? i + 1 : 3);
    end
    err_clr = 1'b1;
    issue(16'h1000, 1'b0, D_1000, 1'b0);
    idle();
    err_clr = 1'b0;
    check("err_clr_priority", {30'd0, err_count}, 32'd0);
    tick();

    // Reset with two buffered entries and a request in the reset cycle
    out_ready = 1'b0;
    issue(16'h0003, 1'b1, 8'h03, 1'b1);
    issue(16'h8000, 1'b1, D_0080 == 8'h7F ? 8'h80 : 8'h00, 1'b0);
    idle();
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    check("pre_rst_err", {30'd0, err_count}, 32'd1);
    rst = 1'b1;
    sb.delete();
    in_valid = 1'b1; in_value = 16'h0004; in_ext_op = 1'b0;
    tick();
    rst = 1'b0;
    idle();
    check_reset_state("midrst");
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_empty", {31'd0, out_valid}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
